exec_mdu_ctrl: RTL and testbench
================================

# exec_mdu_ctrl

Sequencer for a multi-cycle RV64M multiply/divide unit in the execute stage. It latches operands from the ID/EX register and runs an iterative radix-2 shift-add multiply or restoring divide over a fixed number of cycles. It holds the execute stage through `ok_to_proceed` until the result is ready, then presents a sign-corrected 64-bit result for the EX/MEM register. Flushes abort the operation.

## Interface
Parameters:
- `XLEN`, 64, datapath width; W-ops use the low 32 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  ID/EX holds a valid M-extension instruction (`valid & rvm`). Level signal, held stable while `ok_to_proceed`=0.
- `mul_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rv64`  in  1  W-variant: 32-bit operands, 32-bit result sign-extended to 64.
- `ia`, `ib`  in  XLEN  operands.
- `ok_to_proceed_overall`  in  1  global pipeline advance.
- `flush`  in  1  JumpEn: the instruction in EX is killed.
- `ok_to_proceed`  out  1  combinational stall release for this stage.
- `result`  out  XLEN  registered result, valid while `state==DONE`.
- `busy`  out  1  `state` is not IDLE or DONE.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE, `req_valid`=1 and `flush`=0:
  - Latch `op` and `rv64`.
  - Latch operand magnitudes: take the absolute value of signed operands; sign-/zero-extend bit 31 for W.
  - Latch the result-negate flags.
  - Go to PREP.
- PREP:
  - Divisor 0: preset quotient = all ones, remainder = dividend, then go to DONE.
  - Signed overflow (most-negative ÷ −1, at 64 or 32 bits): preset quotient = dividend, remainder = 0, then go to DONE.
  - Otherwise load the iteration counter with 64 (32 for W) and go to RUN.
- RUN: one iteration per cycle.
  - Multiply: 128-bit accumulator, conditional add of multiplicand, shift right.
  - Divide: shift remainder/quotient left, trial-subtract, set quotient bit.
  - Counter decrements each cycle; go to FIX when it reaches 1.
- FIX: result selection.
  - Apply the negate flags.
  - Select low half (MUL) or high half (MULH*), quotient (DIV*) or remainder (REM*).
  - For W, sign-extend bit 31.
  - Register into `result` and go to DONE.
- DONE: hold `result`. When `ok_to_proceed_overall`=1, go to IDLE.
- Sign rules:
  - Quotient is negated when operand signs differ.
  - Remainder takes the dividend's sign.
  - MULHSU negates the product only when `ia` is negative.
- `ok_to_proceed` = `flush` | ~`req_valid` | (`state`==DONE).
- `flush` in any state: go to IDLE next edge. Latched data is discarded and `result` is not updated. `flush` takes priority over all other transitions.
- Reset values: `state`=IDLE, `result`=0, counter=0, `busy`=0.
- Reset mid-operation returns to IDLE with no partial result exposed.

## Timing
- Cycle 0 is the first IDLE cycle with `req_valid`=1.
- 64-bit op: PREP cycle 1, RUN cycles 2–65, FIX cycle 66, DONE cycle 67. `ok_to_proceed`=1 in cycle 67 at the earliest.
- W op: RUN cycles 2–33, FIX 34, DONE 35.
- Special-case divide: DONE at cycle 2.
- DONE with `ok_to_proceed_overall`=0: remain in DONE with `result` stable. No restart even though `req_valid` remains 1.
- Back-to-back M-ops: IDLE is reached on the edge that advances the pipeline, so the next op's cycle 0 is the following cycle. There is no bubble beyond that.

## Structure
- Shared package `common`:
  - `MDU_STATE` enum.
  - funct3 constants `MUL_MUL`…`MUL_REMU`.
  - Existing `u64`/`u32` typedefs.
- One sub-module, `mdu_iter`, holds the iterative datapath:
  - 128-bit accumulator / remainder-quotient register.
  - Adder and subtractor.
  - Controls: `load`, `step`, `is_div`, `width32`.
- `exec_mdu_ctrl` owns the FSM, counter, sign/special-case logic and result select.

## Test plan
- MUL `ia`=3, `ib`=−5, `rv64`=0 → `ok_to_proceed`=0 in cycles 0–66; cycle 67 `result`=0xFFFF_FFFF_FFFF_FFF1, `ok_to_proceed`=1.
- MULHU `ia`=`ib`=0xFFFF_FFFF_FFFF_FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE. MULH of the same operands → 0.
- DIV by zero, `ia`=7 → DONE at cycle 2, `result`=0xFFFF_FFFF_FFFF_FFFF. REM `ia`=7, `ib`=0 → 7.
- DIVW `ia`=0x8000_0000, `ib`=−1 → `result`=0xFFFF_FFFF_8000_0000 at cycle 2. REMW with −7 ÷ 2 → −1 at cycle 35.
- `flush` asserted at cycle 20 of a DIVU → `ok_to_proceed`=1 that cycle; IDLE at cycle 21. A new MUL on cycle 21 completes at cycle 88 with the correct value.
- `ok_to_proceed_overall`=0 for cycles 67–70 after a MUL → `result` held, `state` stays DONE, no restart; returns to IDLE after cycle 71.

Source files
------------

// File: rtl/exec_mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// common: shared definitions for the execute stage.
//   u64 / u32      : plain data word typedefs
//   MDU_STATE      : sequencer states of the multiply/divide unit
//   MUL_*          : funct3 encodings of the RV64M operations
//   opSignedA/B    : which operands an operation treats as signed
// -----------------------------------------------------------------------------
package common;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } MDU_STATE;

  localparam logic [2:0] MUL_MUL    = 3'b000;
  localparam logic [2:0] MUL_MULH   = 3'b001;
  localparam logic [2:0] MUL_MULHSU = 3'b010;
  localparam logic [2:0] MUL_MULHU  = 3'b011;
  localparam logic [2:0] MUL_DIV    = 3'b100;
  localparam logic [2:0] MUL_DIVU   = 3'b101;
  localparam logic [2:0] MUL_REM    = 3'b110;
  localparam logic [2:0] MUL_REMU   = 3'b111;

  // MUL is handled as unsigned: the low half of the product does not depend
  // on operand signedness.
  function automatic logic opSignedA(input logic [2:0] op);
    return (op == MUL_MULH) || (op == MUL_MULHSU) || (op == MUL_DIV) || (op == MUL_REM);
  endfunction

  function automatic logic opSignedB(input logic [2:0] op);
    return (op == MUL_MULH) || (op == MUL_DIV) || (op == MUL_REM);
  endfunction

endpackage

// File: rtl/exec_mdu_ctrl_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter: iterative radix-2 datapath for unsigned magnitudes.
//   Multiply: acc = {high, multiplier}; each step conditionally adds the
//             multiplicand into the high half, then shifts right by one.
//   Divide  : acc = {remainder, quotient}; each step shifts left, trial
//             subtracts the divisor and sets the new quotient bit.
//   width32 confines both algorithms to acc[63:0] (32-bit halves).
// Ports:
//   clk            clock
//   load           capture srcA into the low half (high half cleared) and srcB
//   step           perform one iteration
//   isDiv, width32 algorithm and width select
//   srcA           multiplier / dividend magnitude
//   srcB           multiplicand / divisor magnitude
//   acc            accumulator (product, or {remainder, quotient})
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic              isDiv,
  input  logic              width32,
  input  logic [XLEN-1:0]   srcA,
  input  logic [XLEN-1:0]   srcB,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] accNext;
  logic [XLEN:0]     sumFull;
  logic [XLEN:0]     diffFull;
  logic [32:0]       sumHalf;
  logic [32:0]       diffHalf;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    accNext  = acc;
    sumFull  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    diffFull = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    sumHalf  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd[31:0]} : 33'd0);
    diffHalf = acc[63:31] - {1'b0, opnd[31:0]};

    if (isDiv) begin
      // A clear top bit of the difference means the shifted remainder was
      // not below the divisor: keep the difference and set the quotient bit.
      if (width32)
        accNext = !diffHalf[32] ? {{(2*XLEN-64){1'b0}}, diffHalf[31:0], acc[30:0], 1'b1}
                                : {{(2*XLEN-64){1'b0}}, acc[62:0], 1'b0};
      else
        accNext = !diffFull[XLEN] ? {diffFull[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                                  : {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (width32)
        accNext = {{(2*XLEN-64){1'b0}}, sumHalf, acc[31:1]};
      else
        accNext = {sumFull, acc[XLEN-1:1]};
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded
  // before use and the controller never exposes them outside an operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (load) begin
      acc  <= {{XLEN{1'b0}}, srcA};
      opnd <= srcB;
    end else if (step) begin
      acc  <= accNext;
    end
  end

endmodule

// File: rtl/exec_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// exec_mdu_ctrl: execute-stage sequencer for the RV64M multiply/divide unit.
// Latches operand magnitudes and sign flags, runs mdu_iter for 64 (or 32 for
// W-ops) cycles, then sign-corrects and selects the result. Divide by zero
// and signed overflow bypass the iteration. The stage is held through
// ok_to_proceed until the result is ready; flush aborts at any point.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid                valid M-extension instruction in ID/EX
//   mul_op, rv64             funct3 and W-variant select
//   ia, ib                   operands
//   ok_to_proceed_overall    global pipeline advance
//   flush                    kill the instruction in EX
//   ok_to_proceed            stall release for this stage
//   result                   registered result, valid in DONE
//   busy                     operation in flight (not IDLE, not DONE)
// -----------------------------------------------------------------------------
module exec_mdu_ctrl
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      mul_op,
  input  logic            rv64,
  input  logic [XLEN-1:0] ia,
  input  logic [XLEN-1:0] ib,
  input  logic            ok_to_proceed_overall,
  input  logic            flush,
  output logic            ok_to_proceed,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  function automatic logic [XLEN-1:0] sextW(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zextW(input logic [XLEN-1:0] v);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  MDU_STATE          state;
  logic [6:0]        cnt;
  logic [2:0]        op;
  logic              isW;
  logic [XLEN-1:0]   aExt, bExt, magA, magB;
  logic              negProd, negRem;
  logic [2*XLEN-1:0] acc;

  // Operand conditioning on the incoming instruction
  logic            inSgnA, inSgnB, inNegA, inNegB;
  logic [XLEN-1:0] inA, inB, inMagA, inMagB;

  always_comb begin
    inSgnA = opSignedA(mul_op);
    inSgnB = opSignedB(mul_op);
    inA    = rv64 ? (inSgnA ? sextW(ia) : zextW(ia)) : ia;
    inB    = rv64 ? (inSgnB ? sextW(ib) : zextW(ib)) : ib;
    inNegA = inSgnA & inA[XLEN-1];
    inNegB = inSgnB & inB[XLEN-1];
    inMagA = inNegA ? -inA : inA;
    inMagB = inNegB ? -inB : inB;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && !flush) begin
      op      <= mul_op;
      isW     <= rv64;
      aExt    <= inA;
      bExt    <= inB;
      magA    <= inMagA;
      magB    <= inMagB;
      negProd <= inNegA ^ inNegB;  // also the quotient sign
      negRem  <= inNegA;           // remainder follows the dividend
    end
  end

  // Special-case divides, resolved in PREP without iterating
  logic [XLEN-1:0] minNeg, specialRes;
  logic            divZero, divOvf, special;

  always_comb begin
    minNeg     = isW ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    divZero    = (bExt == '0);
    divOvf     = opSignedA(op) && (aExt == minNeg) && (&bExt);
    special    = op[2] && (divZero || divOvf);
    specialRes = divZero ? (op[1] ? aExt : '1) : (op[1] ? '0 : aExt);
    if (isW)
      specialRes = sextW(specialRes);
  end

  // Result selection from the finished accumulator
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fixRes;

  always_comb begin
    prod = negProd ? -acc : acc;
    quot = isW ? zextW(acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = isW ? zextW(acc[63:32]) : acc[2*XLEN-1:XLEN];
    if (op[2])
      fixRes = op[1] ? (negRem ? -rem : rem) : (negProd ? -quot : quot);
    else if (op[1:0] == 2'b00)
      fixRes = prod[XLEN-1:0];
    else
      fixRes = isW ? zextW(prod[XLEN-1:0] >> 32) : prod[2*XLEN-1:XLEN];
    if (isW)
      fixRes = sextW(fixRes);
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .load    (state == PREP),
    .step    (state == RUN),
    .isDiv   (op[2]),
    .width32 (isW),
    .srcA    (magA),
    .srcB    (magB),
    .acc     (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) state <= PREP;
        PREP: begin
          if (special) begin
            result <= specialRes;
            state  <= DONE;
          end else begin
            cnt   <= isW ? 7'd32 : 7'd64;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIX;
        end
        FIX: begin
          result <= fixRes;
          state  <= DONE;
        end
        DONE:    if (ok_to_proceed_overall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ok_to_proceed = flush | ~req_valid | (state == DONE);
  assign busy          = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_exec_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for exec_mdu_ctrl. Expected results come from an arithmetic
// reference model (full-width products, native division); expected latency
// comes from the cycle counts of the timing rules. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_exec_mdu_ctrl;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  mul_op;
  logic        rv64;
  logic [63:0] ia, ib;
  logic        ok_to_proceed_overall;
  logic        flush;
  logic        ok_to_proceed;
  logic [63:0] result;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] expRes;
  int          expLat;

  always #5 clk = ~clk;

  exec_mdu_ctrl #(.XLEN(64)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .mul_op                (mul_op),
    .rv64                  (rv64),
    .ia                    (ia),
    .ib                    (ib),
    .ok_to_proceed_overall (ok_to_proceed_overall),
    .flush                 (flush),
    .ok_to_proceed         (ok_to_proceed),
    .result                (result),
    .busy                  (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Divide operands as the spec defines them: W-ops use the low 32 bits.
  function automatic logic [63:0] divOperand(input logic sgn, input logic w, input logic [63:0] v);
    if (!w) return v;
    return sgn ? sext32(v) : {32'd0, v[31:0]};
  endfunction

  function automatic logic isSpecialDiv(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, minv;
    if (!op[2]) return 1'b0;
    x    = divOperand(~op[0], w, a);
    y    = divOperand(~op[0], w, b);
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    return (y == 64'd0) || (!op[0] && x == minv && y == '1);
  endfunction

  function automatic logic [63:0] refModel(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub;
    logic [127:0]        p;
    logic [63:0]         x, y, q, r, minv;
    logic                sgn;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    if (!op[2]) begin
      case (op[1:0])
        2'b01:   p = sa * sb;
        2'b10:   p = sa * ub;
        default: p = ua * ub;
      endcase
      if (op[1:0] == 2'b00) return w ? sext32(p[63:0]) : p[63:0];
      return p[127:64];
    end
    sgn  = ~op[0];
    x    = divOperand(sgn, w, a);
    y    = divOperand(sgn, w, b);
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (y == 64'd0) begin
      q = '1;
      r = x;
    end else if (sgn && x == minv && y == '1) begin
      q = x;
      r = 64'd0;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return w ? sext32(op[1] ? r : q) : (op[1] ? r : q);
  endfunction

  function automatic int refLat(input logic [2:0] op, input logic w,
                                input logic [63:0] a, input logic [63:0] b);
    if (isSpecialDiv(op, w, a, b)) return 2;
    return w ? 35 : 67;
  endfunction

  // Present an instruction in its cycle 0 (called at a falling edge, unit idle).
  task automatic startOp(input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
    mul_op    = op;
    rv64      = w;
    ia        = a;
    ib        = b;
    req_valid = 1'b1;
    expRes    = refModel(op, w, a, b);
    expLat    = refLat(op, w, a, b);
    #1;
    check("stall_c0", 64'(ok_to_proceed), 64'd0);
  endtask

  // Wait (bounded) for the stall release and check latency and result.
  task automatic finishOp(input string tag);
    int cyc = 0;
    while (ok_to_proceed !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(expLat));
    check({tag, "_res"}, result, expRes);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    startOp(op, w, a, b);
    finishOp(tag);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] prevRes, ra, rb;
    logic [2:0]  rop;
    logic        rw;

    rst = 1'b1; req_valid = 1'b0; mul_op = 3'd0; rv64 = 1'b0;
    ia = 64'd0; ib = 64'd0; ok_to_proceed_overall = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ok", 64'(ok_to_proceed), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    runOp("mul_3x-5",   MUL_MUL,   1'b0, 64'd3, -64'sd5);
    runOp("mulhu_ones", MUL_MULHU, 1'b0, '1, '1);
    runOp("mulh_ones",  MUL_MULH,  1'b0, '1, '1);
    runOp("div_by0",    MUL_DIV,   1'b0, 64'd7, 64'd0);
    runOp("rem_by0",    MUL_REM,   1'b0, 64'd7, 64'd0);
    runOp("divw_ovf",   MUL_DIV,   1'b1, 64'h0000_0000_8000_0000, '1);
    runOp("remw_-7_2",  MUL_REM,   1'b1, -64'sd7, 64'd2);
    runOp("div_ovf64",  MUL_DIV,   1'b0, 64'h8000_0000_0000_0000, '1);

    // Flush during a DIVU, then a MUL right behind it
    prevRes = result;
    startOp(MUL_DIVU, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd12345);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_ok", 64'(ok_to_proceed), 64'd1);
    @(negedge clk);
    check("flush_idle", 64'(busy), 64'd0);
    check("flush_keep", result, prevRes);
    flush = 1'b0;
    startOp(MUL_MUL, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'h0000_0001_0000_0003);
    finishOp("post_flush_mul");
    @(negedge clk);

    // Pipeline held in DONE for cycles 67..70
    ok_to_proceed_overall = 1'b0;
    startOp(MUL_MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    finishOp("hold_mul");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_ok", 64'(ok_to_proceed), 64'd1);
      check("hold_res", result, expRes);
    end
    @(negedge clk);
    ok_to_proceed_overall = 1'b1;
    check("hold_c71_ok", 64'(ok_to_proceed), 64'd1);
    @(negedge clk);
    check("hold_idle_ok", 64'(ok_to_proceed), 64'd0);
    check("hold_idle_busy", 64'(busy), 64'd0);
    startOp(MUL_MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    finishOp("hold_restart");
    @(negedge clk);

    // Randomized back-to-back operations
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = (rop[2] || rop == MUL_MUL) ? 1'($urandom_range(0, 1)) : 1'b0;
      ra  = pickOperand();
      rb  = pickOperand();
      runOp($sformatf("rnd%0d_op%0d_w%0d", i, rop, rw), rop, rw, ra, rb);
    end

    // Reset in the middle of an operation
    startOp(MUL_DIV, 1'b0, 64'd1000, 64'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", result, 64'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_ok", 64'(ok_to_proceed), 64'd1);
    check("midrst_result2", result, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
